// File: rtl/tri_dispatcher.sv
// Triangle dispatcher: FIFO of setup-stage triangles, off-screen culling on the head,
// one-at-a-time issue to the rasterizer, and frame-drain tracking.
module tri_dispatcher #(
    parameter int DEPTH = 4,
    parameter int SCR_W = 320,
    parameter int SCR_H = 240
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_tri_valid,
    output logic         o_tri_ready,
    input  logic [311:0] i_tri_data,
    input  logic         i_frame_end,
    output logic         o_rast_valid,
    input  logic         i_rast_busy,
    output logic [311:0] o_rast_data,
    output logic         o_frame_done,
    output logic [15:0]  o_cull_count,
    output logic         o_idle
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic signed [15:0] X_LIM = 16'(SCR_W - 1);
    localparam logic signed [15:0] Y_LIM = 16'(SCR_H - 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_ISSUE     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [311:0]   mem [DEPTH];
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [1:0]     state_q, state_d;
    logic [311:0]   rast_data_q, rast_data_d;
    logic [15:0]    cull_q, cull_d;
    logic           frame_pend_q, frame_pend_d;

    logic           empty, full, push, pop, off, frame_done;
    logic [311:0]   head;
    logic signed [15:0] x0, y0, x1, y1, x2, y2;
    logic signed [15:0] min_x, max_x, min_y, max_y;

    function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign push  = i_tri_valid && !full;
    assign head  = mem[rd_ptr_q];

    assign x0 = head[311:296];
    assign y0 = head[295:280];
    assign x1 = head[279:264];
    assign y1 = head[263:248];
    assign x2 = head[247:232];
    assign y2 = head[231:216];

    // Bounding-box test only; degenerate triangles are left for the rasterizer.
    always_comb begin
        min_x = min3(x0, x1, x2);
        max_x = max3(x0, x1, x2);
        min_y = min3(y0, y1, y2);
        max_y = max3(y0, y1, y2);
        off   = (max_x < 16'sd0) || (min_x > X_LIM) || (max_y < 16'sd0) || (min_y > Y_LIM);
    end

    always_comb begin
        state_d      = state_q;
        rast_data_d  = rast_data_q;
        cull_d       = cull_q;
        frame_pend_d = frame_pend_q;
        pop          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && !i_rast_busy) begin
                    pop = 1'b1;
                    if (off) begin
                        if (cull_q != 16'hFFFF) cull_d = cull_q + 16'd1;
                    end else begin
                        rast_data_d = head;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE:     state_d = S_WAIT_BUSY;
            // Busy only rises the cycle after the start pulse; don't mistake its low for done.
            S_WAIT_BUSY: if (i_rast_busy) state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (!i_rast_busy) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        frame_done = frame_pend_q && empty && (state_q == S_IDLE) && !i_rast_busy;
        if (frame_done)  frame_pend_d = 1'b0;
        if (i_frame_end) frame_pend_d = 1'b1;
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q] <= i_tri_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= S_IDLE;
            rast_data_q  <= '0;
            cull_q       <= '0;
            frame_pend_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            rast_data_q  <= rast_data_d;
            cull_q       <= cull_d;
            frame_pend_q <= frame_pend_d;
        end
    end

    assign o_tri_ready  = !full;
    assign o_rast_valid = (state_q == S_ISSUE) && !i_rst;
    assign o_frame_done = frame_done && !i_rst;
    assign o_rast_data  = rast_data_q;
    assign o_cull_count = cull_q;
    assign o_idle       = empty && (state_q == S_IDLE) && !i_rast_busy;

endmodule
